rgmii_rx_delay_cal: RTL and testbench
=====================================

// Module: rgmii_rx_delay_cal
// PURPOSE
//  Calibrates the RX clock delay step (10 ps/step) that feeds the RGMII RX clock-delay cell.
//  Sweeps the step range and scores each step by checking received preambles on the GMII-side bus.
//  Selects the centre of the widest passing window and drives that step.
//  Sits beside rgmii_rx, in the rgmii_clk domain; started by the board/UDP control logic.
// PARAMETERS
//  STEP_MIN      8'd0      first step swept
//  STEP_MAX      8'd247    last step swept (hard limit 247)
//  STEP_INC      8'd8      sweep increment, >=1
//  DEFAULT_STEP  8'hA0     step driven after reset and after a failed calibration
//  SETTLE_CYC    16'd1024  cycles waited after each step load before scoring
//  OBS_FRAMES    8'd16     frames that must pass for a step to pass
//  TIMEOUT_CYC   24'd1250000  per-step observation limit; expiry = step fails
//  MIN_PRE       3'd5      minimum 0x55 bytes before SFD
// PORTS
//  rgmii_clk          in   1  delayed RX clock; all logic on rising edge
//  rst                in   1  async, active-high reset
//  cal_start          in   1  1-cycle strobe; starts a sweep when idle
//  mac_rx_data_valid  in   1  GMII RX valid from rgmii_rx
//  mac_rx_error       in   1  GMII RX error from rgmii_rx
//  mac_rx_data        in   8  GMII RX byte from rgmii_rx
//  delay_step         out  8  step value for the clock-delay cell
//  delay_load         out  1  1-cycle strobe on every delay_step change
//  cal_busy           out  1  sweep in progress
//  cal_done           out  1  1-cycle strobe at sweep end (pass or fail)
//  cal_fail           out  1  sticky until next cal_start: no passing step found
//  eye_width          out  8  number of passing steps in the chosen window
// BEHAVIOUR
//  Reset: delay_step=DEFAULT_STEP; delay_load, cal_busy, cal_done, cal_fail=0; eye_width=0; FSM=IDLE.
//  FSM: IDLE -> LOAD -> SETTLE -> OBSERVE -> JUDGE -> (LOAD | APPLY) -> IDLE.
//   IDLE: cal_start=1 -> clear cal_fail/window regs, cur=STEP_MIN, go LOAD. cal_start while busy: ignored.
//   LOAD: delay_step<=cur, delay_load=1 for 1 cycle; go SETTLE.
//   SETTLE: count SETTLE_CYC cycles, ignore the bus; a frame in flight at exit is not scored.
//   OBSERVE: score frames starting on a valid 0->1 edge; good=0, bad=0, tmo counter from 0.
//    Frame is good iff: the first bytes are 0x55 (>=MIN_PRE of them), then 0xD5, with mac_rx_error=0
//    through the SFD. Any other byte or error before the SFD, or valid dropping before the SFD -> bad.
//    Bytes after the SFD are not checked. Exit when good==OBS_FRAMES, on the first bad, or when tmo==TIMEOUT_CYC.
//   JUDGE (1 cycle): pass = (good==OBS_FRAMES && bad==0).
//    pass: if no run is open, run_start=cur; run_len++.
//    fail, or pass with cur is last step: close the run; if run_len > best_len then best_len=run_len,
//    best_lo=run_start. On equal lengths the lower window is kept.
//    Next: cur+STEP_INC computed in 9 bits; >STEP_MAX or carry -> APPLY, else cur+=STEP_INC, LOAD.
//   APPLY: best_len>0 -> delay_step=best_lo+((best_len-1)*STEP_INC>>1) (9-bit math, floored),
//    eye_width=best_len, cal_fail=0. best_len==0 -> delay_step=DEFAULT_STEP, eye_width=0, cal_fail=1.
//    delay_load pulses only if delay_step changed. Same cycle: cal_done=1, cal_busy=0, go IDLE.
//  cal_busy=1 from the cycle after an accepted cal_start through the APPLY cycle.
//  The delay change glitches rgmii_clk; SETTLE absorbs it. No CDC inside this block.
//  Async rst mid-sweep: everything returns to reset values and DEFAULT_STEP is driven; no cal_done.
//  STEP_MIN==STEP_MAX: exactly one step is scored.
// STRUCTURE
//  Package rgmii_cal_pkg: FSM state enum; PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5; STEP_LIMIT=8'd247.
//  Sub-module rgmii_preamble_checker: frame-start detect, preamble/SFD check.
//   Outputs 1-cycle frame_good / frame_bad strobes; enabled only in OBSERVE.
//  Top: FSM, settle/timeout/frame counters, window tracking, step arithmetic.
// TESTING
//  Use STEP_MIN=0, STEP_MAX=40, STEP_INC=8, OBS_FRAMES=4, SETTLE_CYC=16, TIMEOUT_CYC=2000.
//  1 Bus model passes at steps 16/24/32 only.
//    Expect: load strobes at 0,8,16,24,32,40; final delay_step=24; eye_width=3; cal_fail=0; one cal_done.
//  2 Passes at 0,8 and 32,40 (tie).
//    Expect: delay_step=4 (lower window kept); eye_width=2.
//  3 No traffic at all.
//    Expect: every step times out; delay_step=8'hA0; cal_fail=1; cal_done pulses; total time >= 6*2000 cycles.
//  4 Preamble with only 4x 0x55 before 0xD5, or mac_rx_error set mid-preamble.
//    Expect: that step fails immediately; an SFD-less frame that drops valid also fails.
//  5 rst during OBSERVE at step 16.
//    Expect: delay_step=8'hA0, cal_busy=0, no cal_done. A new cal_start then completes normally.
//  6 cal_start re-pulsed while busy.
//    Expect: ignored; the sweep result is unchanged.

Source files
------------

// File: rtl/rgmii_cal_pkg.sv
// Shared types and constants for the RGMII RX clock-delay calibration block.
package rgmii_cal_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SETTLE,
        ST_OBSERVE,
        ST_JUDGE,
        ST_APPLY
    } cal_state_e;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam logic [7:0] STEP_LIMIT    = 8'd247;

endpackage

// File: rtl/rgmii_preamble_checker.sv
// Scores GMII RX frames: a frame starts on a valid 0->1 edge and is judged at its SFD.
// Emits one-cycle frame_good_o / frame_bad_o strobes, one cycle after the deciding byte.
module rgmii_preamble_checker
    import rgmii_cal_pkg::*;
#(
    parameter logic [2:0] MIN_PRE = 3'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic       valid_i,
    input  logic       error_i,
    input  logic [7:0] data_i,
    output logic       frame_good_o,
    output logic       frame_bad_o
);

    logic       prev_valid_q;
    logic       active_q;
    logic [2:0] pre_cnt_q;
    logic       frame_good_q;
    logic       frame_bad_q;

    logic       frame_byte_d;
    logic [2:0] pre_cnt_d;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        frame_byte_d = en_i && valid_i && (active_q || !prev_valid_q);
        pre_cnt_d    = active_q ? pre_cnt_q : 3'd0;
    end

    // NOTE: non-blocking assignments make every register here sample pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_valid_q <= 1'b0;
            active_q     <= 1'b0;
            pre_cnt_q    <= 3'd0;
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;
        end else begin
            prev_valid_q <= valid_i;
            frame_good_q <= 1'b0;
            frame_bad_q  <= 1'b0;
            if (!en_i) begin
                active_q <= 1'b0;
            end else if (frame_byte_d) begin
                if (error_i || (data_i != PREAMBLE_BYTE && data_i != SFD_BYTE)) begin
                    frame_bad_q <= 1'b1;
                    active_q    <= 1'b0;
                end else if (data_i == SFD_BYTE) begin
                    frame_good_q <= (pre_cnt_d >= MIN_PRE);
                    frame_bad_q  <= (pre_cnt_d <  MIN_PRE);
                    active_q     <= 1'b0;
                end else begin
                    // Saturate so long preambles never wrap below MIN_PRE.
                    active_q  <= 1'b1;
                    pre_cnt_q <= (pre_cnt_d == 3'd7) ? pre_cnt_d : pre_cnt_d + 3'd1;
                end
            end else if (active_q) begin
                frame_bad_q <= 1'b1;
                active_q    <= 1'b0;
            end
        end
    end

    assign frame_good_o = frame_good_q;
    assign frame_bad_o  = frame_bad_q;

endmodule

// File: rtl/rgmii_rx_delay_cal.sv
// Sweeps the RX clock-delay step, scores each step on received preambles and
// drives the centre of the widest passing window (lowest window wins ties).
module rgmii_rx_delay_cal
    import rgmii_cal_pkg::*;
#(
    parameter logic [7:0]  STEP_MIN     = 8'd0,
    parameter logic [7:0]  STEP_MAX     = 8'd247,
    parameter logic [7:0]  STEP_INC     = 8'd8,
    parameter logic [7:0]  DEFAULT_STEP = 8'hA0,
    parameter logic [15:0] SETTLE_CYC   = 16'd1024,
    parameter logic [7:0]  OBS_FRAMES   = 8'd16,
    parameter logic [23:0] TIMEOUT_CYC  = 24'd1250000,
    parameter logic [2:0]  MIN_PRE      = 3'd5
) (
    input  logic       rgmii_clk,
    input  logic       rst,
    input  logic       cal_start,
    input  logic       mac_rx_data_valid,
    input  logic       mac_rx_error,
    input  logic [7:0] mac_rx_data,
    output logic [7:0] delay_step,
    output logic       delay_load,
    output logic       cal_busy,
    output logic       cal_done,
    output logic       cal_fail,
    output logic [7:0] eye_width
);

    localparam logic [7:0] STEP_TOP = (STEP_MAX > STEP_LIMIT) ? STEP_LIMIT : STEP_MAX;

    cal_state_e  state_q;
    logic [7:0]  cur_q;
    logic [15:0] settle_cnt_q;
    logic [23:0] tmo_q;
    logic [7:0]  good_q;
    logic        bad_q;
    logic        run_open_q;
    logic [7:0]  run_start_q, run_len_q;
    logic [7:0]  best_lo_q, best_len_q;
    logic [7:0]  delay_step_q, eye_width_q;
    logic        delay_load_q, cal_busy_q, cal_done_q, cal_fail_q;
    logic        frame_good, frame_bad;

    logic [8:0]  next_step_d, centre_d;
    logic        step_pass_d, last_step_d;
    logic [7:0]  open_start_d, open_len_d, close_start_d, close_len_d, apply_step_d;

    rgmii_preamble_checker #(.MIN_PRE(MIN_PRE)) u_checker (
        .clk          (rgmii_clk),
        .rst          (rst),
        .en_i         (state_q == ST_OBSERVE),
        .valid_i      (mac_rx_data_valid),
        .error_i      (mac_rx_error),
        .data_i       (mac_rx_data),
        .frame_good_o (frame_good),
        .frame_bad_o  (frame_bad)
    );

    always_comb begin
        next_step_d   = {1'b0, cur_q} + {1'b0, STEP_INC};
        last_step_d   = next_step_d > {1'b0, STEP_TOP};
        step_pass_d   = (good_q == OBS_FRAMES) && !bad_q;
        open_start_d  = run_open_q ? run_start_q : cur_q;
        open_len_d    = run_open_q ? run_len_q + 8'd1 : 8'd1;
        close_start_d = step_pass_d ? open_start_d : run_start_q;
        close_len_d   = step_pass_d ? open_len_d : run_len_q;
        centre_d      = {1'b0, best_lo_q} + ((9'(best_len_q - 8'd1) * {1'b0, STEP_INC}) >> 1);
        apply_step_d  = (best_len_q != 8'd0) ? centre_d[7:0] : DEFAULT_STEP;
    end

    always_ff @(posedge rgmii_clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_q        <= STEP_MIN;
            settle_cnt_q <= 16'd0;
            tmo_q        <= 24'd0;
            good_q       <= 8'd0;
            bad_q        <= 1'b0;
            run_open_q   <= 1'b0;
            run_start_q  <= 8'd0;
            run_len_q    <= 8'd0;
            best_lo_q    <= 8'd0;
            best_len_q   <= 8'd0;
            delay_step_q <= DEFAULT_STEP;
            eye_width_q  <= 8'd0;
            delay_load_q <= 1'b0;
            cal_busy_q   <= 1'b0;
            cal_done_q   <= 1'b0;
            cal_fail_q   <= 1'b0;
        end else begin
            delay_load_q <= 1'b0;
            cal_done_q   <= 1'b0;
            unique case (state_q)
                ST_IDLE: if (cal_start) begin
                    cal_fail_q <= 1'b0;
                    run_open_q <= 1'b0;
                    run_len_q  <= 8'd0;
                    best_len_q <= 8'd0;
                    best_lo_q  <= 8'd0;
                    cur_q      <= STEP_MIN;
                    cal_busy_q <= 1'b1;
                    state_q    <= ST_LOAD;
                end
                ST_LOAD: begin
                    delay_step_q <= cur_q;
                    delay_load_q <= 1'b1;
                    settle_cnt_q <= 16'd0;
                    state_q      <= ST_SETTLE;
                end
                ST_SETTLE: if (settle_cnt_q == SETTLE_CYC - 16'd1) begin
                    good_q  <= 8'd0;
                    bad_q   <= 1'b0;
                    tmo_q   <= 24'd0;
                    state_q <= ST_OBSERVE;
                end else begin
                    settle_cnt_q <= settle_cnt_q + 16'd1;
                end
                ST_OBSERVE: if (good_q == OBS_FRAMES || bad_q || tmo_q == TIMEOUT_CYC) begin
                    state_q <= ST_JUDGE;
                end else begin
                    tmo_q <= tmo_q + 24'd1;
                    if (frame_good) good_q <= good_q + 8'd1;
                    if (frame_bad)  bad_q  <= 1'b1;
                end
                ST_JUDGE: begin
                    // A passing last step closes its run here so it can still win.
                    if (step_pass_d && !last_step_d) begin
                        run_open_q  <= 1'b1;
                        run_start_q <= open_start_d;
                        run_len_q   <= open_len_d;
                    end else begin
                        if (close_len_d > best_len_q) begin
                            best_len_q <= close_len_d;
                            best_lo_q  <= close_start_d;
                        end
                        run_open_q <= 1'b0;
                        run_len_q  <= 8'd0;
                    end
                    if (last_step_d) begin
                        state_q <= ST_APPLY;
                    end else begin
                        cur_q   <= next_step_d[7:0];
                        state_q <= ST_LOAD;
                    end
                end
                ST_APPLY: begin
                    delay_step_q <= apply_step_d;
                    delay_load_q <= (apply_step_d != delay_step_q);
                    eye_width_q  <= best_len_q;
                    cal_fail_q   <= (best_len_q == 8'd0);
                    cal_done_q   <= 1'b1;
                    cal_busy_q   <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign delay_step = delay_step_q;
    assign delay_load = delay_load_q;
    assign cal_busy   = cal_busy_q;
    assign cal_done   = cal_done_q;
    assign cal_fail   = cal_fail_q;
    assign eye_width  = eye_width_q;

endmodule

// File: tb/tb_rgmii_rx_delay_cal.sv
// Randomised bench for rgmii_rx_delay_cal: a bus model whose frame quality depends on the
// driven step, and a sweep-level reference model checked every cycle.
module tb_rgmii_rx_delay_cal;

    localparam logic [7:0]  STEP_MIN    = 8'd0;
    localparam logic [7:0]  STEP_MAX    = 8'd40;
    localparam logic [7:0]  STEP_INC    = 8'd8;
    localparam logic [7:0]  OBS_FRAMES  = 8'd4;
    localparam logic [15:0] SETTLE_CYC  = 16'd16;
    localparam logic [23:0] TIMEOUT_CYC = 24'd2000;
    localparam int          NSTEPS      = 6;
    localparam int          BUDGET      = 20000;

    typedef enum int {M_GOOD, M_SHORT, M_ERR, M_DROP, M_WRONG, M_SILENT} mode_e;

    logic       clk = 1'b0;
    logic       rst;
    logic       cal_start;
    logic       valid, err;
    logic [7:0] data;
    logic [7:0] delay_step, eye_width;
    logic       delay_load, cal_busy, cal_done, cal_fail;

    mode_e      mode_arr [NSTEPS];
    int         n_checks = 0;
    int         n_pass   = 0;

    bit         exp_busy, start_pending, outstanding;
    logic [7:0] prev_step;
    logic [8:0] exp_loads [$];
    logic [7:0] exp_fstep, exp_eye;
    bit         exp_fail;

    rgmii_rx_delay_cal #(
        .STEP_MIN(STEP_MIN), .STEP_MAX(STEP_MAX), .STEP_INC(STEP_INC), .DEFAULT_STEP(8'hA0),
        .SETTLE_CYC(SETTLE_CYC), .OBS_FRAMES(OBS_FRAMES), .TIMEOUT_CYC(TIMEOUT_CYC), .MIN_PRE(3'd5)
    ) dut (
        .rgmii_clk         (clk),
        .rst               (rst),
        .cal_start         (cal_start),
        .mac_rx_data_valid (valid),
        .mac_rx_error      (err),
        .mac_rx_data       (data),
        .delay_step        (delay_step),
        .delay_load        (delay_load),
        .cal_busy          (cal_busy),
        .cal_done          (cal_done),
        .cal_fail          (cal_fail),
        .eye_width         (eye_width)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic mode_e mode_of(input logic [7:0] step);
        int s = int'(step);
        if (s >= int'(STEP_MIN) && s <= int'(STEP_MAX) && (s - int'(STEP_MIN)) % int'(STEP_INC) == 0)
            return mode_arr[(s - int'(STEP_MIN)) / int'(STEP_INC)];
        return M_SILENT;
    endfunction

    // Widest run of passing steps, lowest on ties, centre floored.
    function automatic void model_sweep(output logic [7:0] fstep, output logic [7:0] eye, output bit fail);
        int best_len = 0, best_lo = 0, len = 0, lo = 0;
        for (int i = 0; i < NSTEPS; i++) begin
            if (mode_arr[i] == M_GOOD) begin
                if (len == 0) lo = int'(STEP_MIN) + i * int'(STEP_INC);
                len++;
                if (len > best_len) begin best_len = len; best_lo = lo; end
            end else begin
                len = 0;
            end
        end
        fail  = (best_len == 0);
        eye   = 8'(best_len);
        fstep = fail ? 8'hA0 : 8'(best_lo + ((best_len - 1) * int'(STEP_INC)) / 2);
    endfunction

    // Compare process: reset values, busy window, every delay_step value, sweep results.
    always @(negedge clk) begin
        logic [8:0] exp_step;
        int         last_s;
        if (rst) begin
            exp_busy = 0; start_pending = 0; outstanding = 0;
            exp_loads.delete();
            prev_step = 8'hA0;
            check("rst_delay_step", delay_step, 8'hA0);
            check("rst_cal_busy", cal_busy, 0);
            check("rst_cal_done", cal_done, 0);
            check("rst_delay_load", delay_load, 0);
            check("rst_cal_fail", cal_fail, 0);
            check("rst_eye_width", eye_width, 0);
        end else begin
            if (start_pending) begin exp_busy = 1; start_pending = 0; end
            if (cal_done) begin
                check("done_expected", outstanding, 1);
                exp_busy = 0; outstanding = 0;
                check("done_delay_step", delay_step, exp_fstep);
                check("done_eye_width", eye_width, exp_eye);
                check("done_cal_fail", cal_fail, exp_fail);
            end
            check("cal_busy", cal_busy, exp_busy);
            if (delay_load) begin
                if (exp_loads.size() > 0) exp_step = exp_loads.pop_front();
                else exp_step = 9'h100;
            end else begin
                exp_step = {1'b0, prev_step};
            end
            check("delay_step", {24'd0, delay_step}, {23'd0, exp_step});
            prev_step = delay_step;
            if (cal_start && !exp_busy) begin
                start_pending = 1; outstanding = 1;
                model_sweep(exp_fstep, exp_eye, exp_fail);
                exp_loads.delete();
                last_s = 0;
                for (int s = int'(STEP_MIN); s <= int'(STEP_MAX); s += int'(STEP_INC)) begin
                    exp_loads.push_back(9'(s));
                    last_s = s;
                end
                if (int'(exp_fstep) != last_s) exp_loads.push_back({1'b0, exp_fstep});
            end
        end
    end

    task automatic drive(input logic v, input logic e, input logic [7:0] d);
        @(posedge clk); #1;
        valid = v; err = e; data = d;
    endtask

    // Bus model: frame quality is chosen from the step currently driven.
    initial begin
        int    pre, eidx;
        mode_e m;
        logic [7:0] b;
        valid = 1'b0; err = 1'b0; data = 8'h00;
        forever begin
            repeat ($urandom_range(1, 6)) drive(1'b0, 1'b0, 8'h00);
            m = mode_of(delay_step);
            case (m)
                M_GOOD, M_SHORT: begin
                    pre = (m == M_GOOD) ? $urandom_range(5, 9) : $urandom_range(0, 4);
                    repeat (pre) drive(1'b1, 1'b0, 8'h55);
                    drive(1'b1, 1'b0, 8'hD5);
                    repeat ($urandom_range(1, 8)) drive(1'b1, 1'b0, 8'($urandom));
                end
                M_ERR: begin
                    pre  = $urandom_range(5, 8);
                    eidx = $urandom_range(0, pre);
                    for (int i = 0; i < pre; i++) drive(1'b1, i == eidx, 8'h55);
                    drive(1'b1, eidx == pre, 8'hD5);
                    repeat ($urandom_range(1, 8)) drive(1'b1, 1'b0, 8'($urandom));
                end
                M_DROP: repeat ($urandom_range(1, 7)) drive(1'b1, 1'b0, 8'h55);
                M_WRONG: begin
                    repeat ($urandom_range(0, 6)) drive(1'b1, 1'b0, 8'h55);
                    b = 8'($urandom);
                    if (b == 8'h55 || b == 8'hD5) b = 8'h00;
                    drive(1'b1, 1'b0, b);
                    repeat ($urandom_range(1, 8)) drive(1'b1, 1'b0, 8'($urandom));
                end
                default: repeat (8) drive(1'b0, 1'b0, 8'h00);
            endcase
        end
    end

    task automatic set_mask(input logic [NSTEPS-1:0] mask);
        for (int i = 0; i < NSTEPS; i++)
            mode_arr[i] = mask[i] ? M_GOOD : mode_e'($urandom_range(1, 4));
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 cal_start = 1'b1;
        @(posedge clk); #1 cal_start = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < BUDGET) begin
            @(negedge clk);
            cycles++;
            seen = cal_done;
        end
        check("sweep_done", seen, 1);
    endtask

    task automatic expect_result(input string tag, input logic [7:0] step, input logic [7:0] eye, input bit fail);
        check({tag, "_delay_step"}, delay_step, step);
        check({tag, "_eye_width"}, eye_width, eye);
        check({tag, "_cal_fail"}, cal_fail, fail);
        check({tag, "_cal_busy"}, cal_busy, 0);
    endtask

    initial begin
        int cycles, dones;
        bit found;
        rst = 1'b1; cal_start = 1'b0;
        for (int i = 0; i < NSTEPS; i++) mode_arr[i] = M_SILENT;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        set_mask(6'b011100);
        pulse_start(); wait_done(cycles);
        expect_result("centre_window", 8'd24, 8'd3, 1'b0);

        set_mask(6'b110011);
        pulse_start(); wait_done(cycles);
        expect_result("tie_lower", 8'd4, 8'd2, 1'b0);

        for (int i = 0; i < NSTEPS; i++) mode_arr[i] = M_SILENT;
        pulse_start(); wait_done(cycles);
        expect_result("no_traffic", 8'hA0, 8'd0, 1'b1);
        check("timeout_duration", cycles >= 12000, 1);

        mode_arr[0] = M_GOOD;  mode_arr[1] = M_SHORT; mode_arr[2] = M_ERR;
        mode_arr[3] = M_DROP;  mode_arr[4] = M_GOOD;  mode_arr[5] = M_GOOD;
        pulse_start(); wait_done(cycles);
        expect_result("bad_preambles", 8'd36, 8'd2, 1'b0);

        set_mask(6'b011100);
        pulse_start();
        found = 0;
        for (int i = 0; i < BUDGET && !found; i++) begin
            @(negedge clk);
            found = delay_load && delay_step == 8'd16;
        end
        check("reach_step16", found, 1);
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_delay_step", delay_step, 8'hA0);
        check("abort_cal_busy", cal_busy, 0);
        dones = 0;
        repeat (100) begin @(negedge clk); if (cal_done) dones++; end
        check("abort_no_done", dones, 0);
        pulse_start(); wait_done(cycles);
        expect_result("after_abort", 8'd24, 8'd3, 1'b0);

        set_mask(6'b110011);
        pulse_start();
        repeat (100) @(posedge clk);
        pulse_start();
        repeat (300) @(posedge clk);
        pulse_start();
        wait_done(cycles);
        expect_result("restart_ignored", 8'd4, 8'd2, 1'b0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NSTEPS; i++) begin
                if ($urandom_range(0, 7) == 0) mode_arr[i] = M_SILENT;
                else if ($urandom_range(0, 1) == 1) mode_arr[i] = M_GOOD;
                else mode_arr[i] = mode_e'($urandom_range(1, 4));
            end
            pulse_start(); wait_done(cycles);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
